mlkem_prog_seq: RTL and testbench



---
 rtl/mlkem_seq_pkg.sv | 33 +++
 rtl/mlkem_seq_wdog.sv | 36 +++
 rtl/mlkem_prog_seq.sv | 161 ++++++++++++++++
 tb/tb_mlkem_prog_seq.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlkem_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mlkem_seq_pkg
// Brief    : Opcodes, instruction field positions and FSM encoding for the
//            ML-KEM microcode sequencer.
// Revision : 1.0
// ============================================================================
package mlkem_seq_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_EXEC    = 4'h1;
  localparam logic [3:0] OP_SETLOOP = 4'h2;
  localparam logic [3:0] OP_JNZ     = 4'h3;
  localparam logic [3:0] OP_END     = 4'hF;

  localparam int OP_HI  = 79;
  localparam int OP_LO  = 76;
  localparam int A_HI   = 75;
  localparam int A_LO   = 66;
  localparam int ARG_HI = 65;
  localparam int ARG_LO = 0;
  localparam int A_W    = A_HI - A_LO + 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FIN    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mlkem_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module   : mlkem_seq_wdog
// Brief    : Loadable down-counter; expiry flag is high once the count that
//            was loaded has fully elapsed.
// Revision : 1.0
// ============================================================================
module mlkem_seq_wdog #(
  parameter int unsigned LIMIT = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_expired
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] r_count;

  // Loaded with LIMIT-1 so that expiry is seen in the LIMIT-th enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= W'(LIMIT - 1);
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mlkem_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : mlkem_prog_seq
// Brief    : Microcode sequencer: fetches ROM words, launches datapath ops,
//            single-level hardware loops. WAIT watchdog with MLKEM_SEQ_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module mlkem_prog_seq
  import mlkem_seq_pkg::*;
#(
  parameter int          INSTR_W     = 80,
  parameter int          ADDR_W      = 10,
  parameter int          ARG_W       = 66,
  parameter int unsigned TIMEOUT_CYC = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [INSTR_W-1:0] rom_q,
  output logic               unit_start,
  output logic [ARG_W-1:0]   unit_arg,
  input  logic               unit_done
);

  state_e              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [A_W-1:0]      r_cnt;

  logic [3:0]          w_op;
  logic [A_W-1:0]      w_a;
  logic [ARG_HI:ARG_LO] w_arg;
  logic                w_cnt_gt1;
  logic                w_adv;
  logic                w_stop;
  logic                w_bad;
  logic                w_wrap;
  logic                w_wd_expired;

  assign w_op      = rom_q[OP_HI:OP_LO];
  assign w_a       = rom_q[A_HI:A_LO];
  assign w_arg     = rom_q[ARG_HI:ARG_LO];
  assign w_cnt_gt1 = (r_cnt > A_W'(1));
  assign rom_addr  = r_pc;

`ifdef MLKEM_SEQ_TIMEOUT_EN
  mlkem_seq_wdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .clk       (clk),
    .rst       (rst),
    .i_load    ((r_state == ST_DECODE) && (w_op == OP_EXEC)),
    .i_en      (r_state == ST_WAIT),
    .o_expired (w_wd_expired)
  );
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_wd_expired     = 1'b0;
`endif

  // w_adv requests pc+1; w_stop ends the program; w_bad marks an error ending.
  // The unit_start term rejects a unit_done that coincides with the launch pulse.
  always_comb begin
    w_adv  = 1'b0;
    w_stop = 1'b0;
    w_bad  = 1'b0;
    case (r_state)
      ST_DECODE: begin
        case (w_op)
          OP_NOP, OP_SETLOOP: w_adv = 1'b1;
          OP_JNZ:             w_adv = !w_cnt_gt1;
          OP_EXEC:            w_adv = 1'b0;
          OP_END:             w_stop = 1'b1;
          default: begin
            w_stop = 1'b1;
            w_bad  = 1'b1;
          end
        endcase
      end
      ST_WAIT: begin
        if (unit_done && !unit_start) begin
          w_adv = 1'b1;
        end else if (w_wd_expired) begin
          w_stop = 1'b1;
          w_bad  = 1'b1;
        end
      end
      default: w_adv = 1'b0;
    endcase
    w_wrap = w_adv && (&r_pc);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_cnt      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      unit_start <= 1'b0;
      unit_arg   <= '0;
    end else begin
      unit_start <= 1'b0;
      done       <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pc    <= '0;
            error   <= 1'b0;
            busy    <= 1'b1;
            r_state <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_DECODE;
        ST_DECODE: begin
          if (w_op == OP_EXEC) begin
            unit_arg   <= ARG_W'(w_arg);
            unit_start <= 1'b1;
            r_state    <= ST_WAIT;
          end
          if (w_op == OP_SETLOOP) begin
            r_cnt <= (w_a == '0) ? A_W'(1) : w_a;
          end
          if (w_op == OP_JNZ) begin
            if (w_cnt_gt1) begin
              r_cnt   <= r_cnt - A_W'(1);
              r_pc    <= ADDR_W'(w_a);
              r_state <= ST_FETCH;
            end else begin
              r_cnt <= '0;
            end
          end
        end
        ST_WAIT: r_state <= ST_WAIT;
        ST_FIN:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase

      // pc never wraps: stepping past the last ROM word ends in error instead.
      if (w_adv && !w_wrap) begin
        r_pc    <= r_pc + ADDR_W'(1);
        r_state <= ST_FETCH;
      end
      if (w_stop || w_wrap) begin
        busy    <= 1'b0;
        done    <= 1'b1;
        r_state <= ST_FIN;
      end
      if (w_bad || w_wrap) begin
        error <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlkem_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mlkem_prog_seq
// Brief    : Directed table-driven bench for mlkem_prog_seq with ROM and
//            datapath-unit models.
// Revision : 1.0
// ============================================================================
module tb_mlkem_prog_seq;

  localparam int INSTR_W = 80;
  localparam int ADDR_W  = 10;
  localparam int ARG_W   = 66;
  localparam int BOUND   = 400;
  localparam logic [65:0] BIG_ARG = 66'h2_DEAD_BEEF_0123_4567;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               busy;
  logic               done;
  logic               error;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_q = '0;
  logic               unit_start;
  logic [ARG_W-1:0]   unit_arg;
  logic               unit_done;

  logic [INSTR_W-1:0] rom [0:1023];
  int lat  = 0;
  int ucnt = 0;
  int n_chk  = 0;
  int n_fail = 0;

  mlkem_prog_seq #(
    .INSTR_W     (INSTR_W),
    .ADDR_W      (ADDR_W),
    .ARG_W       (ARG_W),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .unit_start (unit_start),
    .unit_arg   (unit_arg),
    .unit_done  (unit_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];

  // Unit model: unit_done pulses lat cycles after unit_start; lat=0 never answers.
  always @(posedge clk) begin
    if (unit_start) ucnt <= lat;
    else if (ucnt != 0) ucnt <= ucnt - 1;
  end
  assign unit_done = (ucnt == 1);

  typedef struct {
    int          prog;
    int          lat;
    int          poke;
    int          exp_cyc;
    int          exp_starts;
    logic        exp_err;
    logic [65:0] exp_arg;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] ins(input logic [3:0] op, input int a, input logic [65:0] arg);
    logic [9:0] aa;
    aa = a[9:0];
    return {op, aa, arg};
  endfunction

  task automatic load_prog(input int p);
    for (int i = 0; i < 1024; i++) rom[i] = '0;
    case (p)
      0: begin
        rom[0] = ins(4'h1, 0, 66'h5);
        rom[1] = ins(4'hF, 0, 66'h0);
      end
      1: begin
        rom[0] = ins(4'h2, 4, 66'h0);
        rom[1] = ins(4'h1, 0, BIG_ARG);
        rom[2] = ins(4'h3, 1, 66'h0);
        rom[3] = ins(4'hF, 0, 66'h0);
      end
      2: begin
        rom[0] = ins(4'h2, 0, 66'h0);
        rom[1] = ins(4'h1, 0, 66'h11);
        rom[2] = ins(4'h3, 1, 66'h0);
        rom[3] = ins(4'hF, 0, 66'h0);
      end
      3: begin
        rom[2] = ins(4'h7, 0, 66'h0);
        rom[3] = ins(4'h1, 0, 66'h99);
      end
      4: begin
        rom[1] = ins(4'h3, 0, 66'h0);
        rom[2] = ins(4'h2, 2, 66'h0);
        rom[3] = ins(4'h1, 0, 66'h3);
        rom[4] = ins(4'h3, 3, 66'h0);
        rom[5] = ins(4'hF, 0, 66'h0);
      end
      default: begin
        rom[0] = ins(4'h2, 2, 66'h0);
        rom[1] = ins(4'h3, 1023, 66'h0);
      end
    endcase
  endtask

  // cyc = clock edges from the accepting edge to the edge that raises done.
  task automatic run(input int plat, input int poke, output int cyc, output int nstart);
    lat    = plat;
    nstart = 0;
    cyc    = -1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("pc_zero_at_fetch", rom_addr, 0);
    chk("error_cleared", error, 0);
    for (int k = 1; k <= BOUND; k++) begin
      if (k == poke) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (unit_start) nstart++;
      if (done) begin
        cyc = k;
        break;
      end
    end
    if (cyc < 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d cycles", BOUND);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int ns;

    vecs[0] = '{0, 3, 0,  8, 1, 1'b0, 66'h5,  0};
    vecs[1] = '{0, 1, 0,  6, 1, 1'b0, 66'h5,  0};
    vecs[2] = '{1, 2, 5, 32, 4, 1'b0, BIG_ARG, 0};
    vecs[3] = '{2, 2, 0, 11, 1, 1'b0, 66'h11, 0};
    vecs[4] = '{3, 0, 0,  6, 0, 1'b1, 66'h0,  0};
    vecs[5] = '{4, 1, 3, 20, 2, 1'b0, 66'h3,  0};
    vecs[6] = '{5, 0, 0,  6, 0, 1'b1, 66'h0,  1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_unit_start", unit_start, 0);
    chk("rst_unit_arg", unit_arg, 0);
    @(negedge clk) rst = 1'b0;

    for (int v = 0; v < 7; v++) begin
      load_prog(vecs[v].prog);
      run(vecs[v].lat, vecs[v].poke, cyc, ns);
      chk($sformatf("v%0d_cycles", v), cyc, vecs[v].exp_cyc);
      chk($sformatf("v%0d_unit_starts", v), ns, vecs[v].exp_starts);
      chk($sformatf("v%0d_error", v), error, vecs[v].exp_err);
      chk($sformatf("v%0d_busy_idle", v), busy, 0);
      chk($sformatf("v%0d_done_pulse", v), done, 0);
      chk($sformatf("v%0d_cnt", v), dut.r_cnt, vecs[v].exp_cnt);
      if (ns > 0) chk($sformatf("v%0d_unit_arg", v), unit_arg, vecs[v].exp_arg);
    end

    // Error stays set while idle, then the next start clears it.
    repeat (3) @(posedge clk);
    #1 chk("error_sticky", error, 1);
    load_prog(0);
    run(3, 0, cyc, ns);
    chk("rerun_cycles", cyc, 8);
    chk("rerun_error", error, 0);

    // Reset asserted in the first WAIT cycle, while unit_start is high.
    load_prog(0);
    lat = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 chk("wait_unit_start", unit_start, 1);
    chk("wait_unit_arg", unit_arg, 66'h5);
    rst = 1'b1;
    #1;
    chk("midrst_unit_start", unit_start, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_unit_arg", unit_arg, 0);
    chk("midrst_rom_addr", rom_addr, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    @(negedge clk) rst = 1'b0;
    load_prog(0);
    run(3, 0, cyc, ns);
    chk("postrst_cycles", cyc, 8);
    chk("postrst_starts", ns, 1);
    chk("postrst_error", error, 0);

`ifdef MLKEM_SEQ_TIMEOUT_EN
    load_prog(0);
    run(0, 4, cyc, ns);
    chk("wdog_cycles", cyc, 18);
    chk("wdog_starts", ns, 1);
    chk("wdog_error", error, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
